instruction_fetch: RTL and testbench

Instruction fetch stage: owns the program counter and issues one fetch at a time to the instruction cache over the `inst_addr` / `inst_fetch_enabled` / `inst_fetch_status` interface. It buffers fetched words with their PCs in a 2-entry queue and presents them to decode over a valid/ready handshake. It handles branch redirects from execute by killing any in-flight fetch and flushing the queue.

---
 rtl/instruction_fetch.sv | 167 ++++++++++++++++
 tb/tb_instruction_fetch.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Fetch stage. Owns the PC and issues one fetch at a time to the
//   instruction cache. Fetched words are buffered with their PCs in a 2-entry
//   FIFO and handed to decode over a valid/ready handshake. A redirect from
//   execute kills any in-flight fetch and flushes the FIFO.
//
//   Optional feature: define IF_JAL_PREDICT_EN to follow JAL targets at fetch
//   time instead of falling through to PC+4.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   inst_addr           fetch address to the cache (the PC register)
//   inst_fetch_enabled  fetch request to the cache
//   instruction         fetched word from the cache
//   inst_fetch_status   cache status (IF_FINISHED marks completion)
//   dec_valid           FIFO head valid
//   dec_instruction     FIFO head word
//   dec_pc              FIFO head PC
//   dec_ready           decode accepts the head this cycle
//   redirect            branch/jump redirect pulse
//   redirect_pc         redirect target, valid with redirect
module instruction_fetch #(
  parameter int unsigned            ADDR_WIDTH = 17,
  parameter int unsigned            DATA_LEN   = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [ADDR_WIDTH-1:0]  inst_addr,
  output logic                   inst_fetch_enabled,
  input  logic [DATA_LEN-1:0]    instruction,
  input  logic [1:0]             inst_fetch_status,
  output logic                   dec_valid,
  output logic [DATA_LEN-1:0]    dec_instruction,
  output logic [ADDR_WIDTH-1:0]  dec_pc,
  input  logic                   dec_ready,
  input  logic                   redirect,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc
);

  // Cache status encoding: RESTING=00, WORKING=01, STALL=10, FINISHED=11.
  localparam logic [1:0] IF_FINISHED = 2'b11;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic                   r_armed;
  logic                   r_kill;
  logic [1:0]             r_count;
  logic [ADDR_WIDTH-1:0]  r_q_pc  [2];
  logic [DATA_LEN-1:0]    r_q_ins [2];

  logic                   w_pop;
  logic                   w_complete;
  logic                   w_push;
  logic [1:0]             w_occ_after_pop;
  logic                   w_enter_busy;
  logic [ADDR_WIDTH-1:0]  w_next_pc;

  assign w_pop           = dec_valid && dec_ready;
  assign w_occ_after_pop = r_count - {1'b0, w_pop};
  // armed filters out a FINISHED left over from the previous fetch.
  assign w_complete      = (r_state == S_BUSY) && (inst_fetch_status == IF_FINISHED) && r_armed;
  assign w_push          = w_complete && !r_kill && !redirect;
  assign w_enter_busy    = (r_state == S_IDLE) && (w_state_next == S_BUSY);

`ifdef IF_JAL_PREDICT_EN
  logic signed [20:0] w_jal_imm;
  assign w_jal_imm = {instruction[31], instruction[19:12], instruction[20],
                      instruction[30:21], 1'b0};
`endif

  always_comb begin
    w_next_pc = r_pc + ADDR_WIDTH'(4);
`ifdef IF_JAL_PREDICT_EN
    if (instruction[6:0] == 7'b1101111) begin
      w_next_pc = r_pc + ADDR_WIDTH'(w_jal_imm);
    end
`endif
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_occ_after_pop < 2'd2) w_state_next = S_BUSY;
      S_BUSY:  if (w_complete)             w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    inst_fetch_enabled = (r_state == S_BUSY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc    <= RESET_PC;
      r_armed <= 1'b0;
      r_kill  <= 1'b0;
    end else begin
      if (w_enter_busy)                                             r_armed <= 1'b0;
      else if (r_state == S_BUSY && inst_fetch_status != IF_FINISHED) r_armed <= 1'b1;

      // A completion always retires the in-flight fetch, so kill never
      // outlives it; a redirect on the completing cycle needs no kill.
      if (w_complete)                         r_kill <= 1'b0;
      else if (redirect && r_state == S_BUSY) r_kill <= 1'b1;

      if (redirect)    r_pc <= redirect_pc;
      else if (w_push) r_pc <= w_next_pc;
    end
  end

  // FIFO with the head fixed at entry 0; a pop shifts entry 1 down.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_q_pc[i]  <= '0;
        r_q_ins[i] <= '0;
      end
    end else if (redirect) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          r_q_pc[r_count[0]]  <= r_pc;
          r_q_ins[r_count[0]] <= instruction;
          r_count             <= r_count + 2'd1;
        end
        2'b01: begin
          r_q_pc[0]  <= r_q_pc[1];
          r_q_ins[0] <= r_q_ins[1];
          r_count    <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_q_pc[0]  <= r_pc;
            r_q_ins[0] <= instruction;
          end else begin
            r_q_pc[0]  <= r_q_pc[1];
            r_q_ins[0] <= r_q_ins[1];
            r_q_pc[1]  <= r_pc;
            r_q_ins[1] <= instruction;
          end
        end
        default: ;
      endcase
    end
  end

  assign inst_addr       = r_pc;
  assign dec_valid       = (r_count != 2'd0);
  assign dec_instruction = r_q_ins[0];
  assign dec_pc          = r_q_pc[0];

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  localparam logic [1:0] ST_R = 2'b00;  // resting
  localparam logic [1:0] ST_W = 2'b01;  // working
  localparam logic [1:0] ST_S = 2'b10;  // stall
  localparam logic [1:0] ST_F = 2'b11;  // finished

  localparam logic [31:0] WBAD = 32'hBAD0_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [16:0] inst_addr;
  logic        inst_fetch_enabled;
  logic [31:0] instruction = '0;
  logic [1:0]  inst_fetch_status = ST_R;
  logic        dec_valid;
  logic [31:0] dec_instruction;
  logic [16:0] dec_pc;
  logic        dec_ready = 1'b1;
  logic        redirect = 1'b0;
  logic [16:0] redirect_pc = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instruction_fetch #(
    .ADDR_WIDTH (17),
    .DATA_LEN   (32),
    .RESET_PC   (17'h100)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .inst_addr          (inst_addr),
    .inst_fetch_enabled (inst_fetch_enabled),
    .instruction        (instruction),
    .inst_fetch_status  (inst_fetch_status),
    .dec_valid          (dec_valid),
    .dec_instruction    (dec_instruction),
    .dec_pc             (dec_pc),
    .dec_ready          (dec_ready),
    .redirect           (redirect),
    .redirect_pc        (redirect_pc)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  st;
    logic [31:0] ins;
    logic        rdy;
    logic        rd;
    logic [16:0] rpc;
    logic        en;
    logic [16:0] addr;
    logic        val;
    logic        cd;    // check dec_pc / dec_instruction
    logic [16:0] pc;
    logic [31:0] di;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [1:0] st, input logic [31:0] ins,
                     input logic rdy, input logic rd, input logic [16:0] rpc,
                     input logic en, input logic [16:0] addr, input logic val,
                     input logic cd, input logic [16:0] pc, input logic [31:0] di);
    vec_t v;
    v.rst = r; v.st = st; v.ins = ins; v.rdy = rdy; v.rd = rd; v.rpc = rpc;
    v.en = en; v.addr = addr; v.val = val; v.cd = cd; v.pc = pc; v.di = di;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Cache stand-in: waits (bounded) for the request, then WORKING x2, FINISHED x1.
  task automatic cache_fetch(input logic [31:0] word);
    int unsigned n;
    n = 0;
    inst_fetch_status = ST_R;
    while (!inst_fetch_enabled && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (!inst_fetch_enabled) begin
      n_tests++;
      n_fail++;
      $display("FAIL fetch_request_timeout: enable=%b, expected 1", inst_fetch_enabled);
    end
    inst_fetch_status = ST_W;
    @(posedge clk); #1;
    @(posedge clk); #1;
    inst_fetch_status = ST_F;
    instruction       = word;
    @(posedge clk); #1;
    inst_fetch_status = ST_R;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] exp_jal;
    bit          ok;
    vec_t        v;

    //   rst st    ins           rdy rd rpc       en addr      val cd pc        di
    add(1, ST_R, 32'h0,        1, 0, 17'h0,    0, 17'h100, 0, 1, 17'h0,   32'h0);        // 0 reset
    add(0, ST_R, 32'h0,        1, 0, 17'h0,    1, 17'h100, 0, 0, 17'h0,   32'h0);        // 1 issue
    add(0, ST_W, 32'h0,        1, 0, 17'h0,    1, 17'h100, 0, 0, 17'h0,   32'h0);
    add(0, ST_W, 32'h0,        1, 0, 17'h0,    1, 17'h100, 0, 0, 17'h0,   32'h0);
    add(0, ST_F, 32'h1111_0000,1, 0, 17'h0,    0, 17'h104, 1, 1, 17'h100, 32'h1111_0000);// 4
    add(0, ST_R, 32'h0,        1, 0, 17'h0,    1, 17'h104, 0, 0, 17'h0,   32'h0);
    add(0, ST_W, 32'h0,        1, 0, 17'h0,    1, 17'h104, 0, 0, 17'h0,   32'h0);
    add(0, ST_W, 32'h0,        1, 0, 17'h0,    1, 17'h104, 0, 0, 17'h0,   32'h0);
    add(0, ST_F, 32'h1111_0001,1, 0, 17'h0,    0, 17'h108, 1, 1, 17'h104, 32'h1111_0001);// 8
    add(0, ST_R, 32'h0,        1, 0, 17'h0,    1, 17'h108, 0, 0, 17'h0,   32'h0);
    add(0, ST_W, 32'h0,        1, 0, 17'h0,    1, 17'h108, 0, 0, 17'h0,   32'h0);
    add(0, ST_W, 32'h0,        1, 0, 17'h0,    1, 17'h108, 0, 0, 17'h0,   32'h0);
    add(0, ST_F, 32'h1111_0002,1, 0, 17'h0,    0, 17'h10C, 1, 1, 17'h108, 32'h1111_0002);// 12
    // decode stalls: fill both slots
    add(0, ST_R, 32'h0,        0, 0, 17'h0,    1, 17'h10C, 1, 1, 17'h108, 32'h1111_0002);
    add(0, ST_W, 32'h0,        0, 0, 17'h0,    1, 17'h10C, 1, 1, 17'h108, 32'h1111_0002);
    add(0, ST_W, 32'h0,        0, 0, 17'h0,    1, 17'h10C, 1, 1, 17'h108, 32'h1111_0002);
    add(0, ST_F, 32'h1111_0003,0, 0, 17'h0,    0, 17'h110, 1, 1, 17'h108, 32'h1111_0002);// 16 full
    add(0, ST_R, 32'h0,        0, 0, 17'h0,    0, 17'h110, 1, 1, 17'h108, 32'h1111_0002);
    add(0, ST_R, 32'h0,        0, 0, 17'h0,    0, 17'h110, 1, 1, 17'h108, 32'h1111_0002);
    add(0, ST_R, 32'h0,        1, 0, 17'h0,    1, 17'h110, 1, 1, 17'h10C, 32'h1111_0003);// 19 pop+issue
    add(0, ST_W, 32'h0,        0, 0, 17'h0,    1, 17'h110, 1, 1, 17'h10C, 32'h1111_0003);
    add(0, ST_F, 32'h1111_0004,0, 0, 17'h0,    0, 17'h114, 1, 1, 17'h10C, 32'h1111_0003);// 21
    // FINISHED held over into the next fetch's first BUSY cycle
    add(0, ST_F, WBAD,         1, 0, 17'h0,    1, 17'h114, 1, 1, 17'h110, 32'h1111_0004);// 22
    add(0, ST_F, WBAD,         0, 0, 17'h0,    1, 17'h114, 1, 1, 17'h110, 32'h1111_0004);// 23 ignored
    add(0, ST_W, 32'h0,        0, 0, 17'h0,    1, 17'h114, 1, 1, 17'h110, 32'h1111_0004);
    add(0, ST_F, 32'h1111_0005,0, 0, 17'h0,    0, 17'h118, 1, 1, 17'h110, 32'h1111_0004);// 25
    // redirect to 0x200 during a stalled fetch
    add(0, ST_R, 32'h0,        1, 0, 17'h0,    1, 17'h118, 1, 1, 17'h114, 32'h1111_0005);
    add(0, ST_S, 32'h0,        0, 0, 17'h0,    1, 17'h118, 1, 1, 17'h114, 32'h1111_0005);
    add(0, ST_S, 32'h0,        0, 1, 17'h200,  1, 17'h200, 0, 0, 17'h0,   32'h0);        // 28
    add(0, ST_S, 32'h0,        0, 0, 17'h0,    1, 17'h200, 0, 0, 17'h0,   32'h0);
    add(0, ST_F, WBAD,         0, 0, 17'h0,    0, 17'h200, 0, 0, 17'h0,   32'h0);        // 30 killed
    add(0, ST_R, 32'h0,        0, 0, 17'h0,    1, 17'h200, 0, 0, 17'h0,   32'h0);
    add(0, ST_W, 32'h0,        0, 0, 17'h0,    1, 17'h200, 0, 0, 17'h0,   32'h0);
    add(0, ST_W, 32'h0,        0, 0, 17'h0,    1, 17'h200, 0, 0, 17'h0,   32'h0);
    add(0, ST_F, 32'h1111_0006,0, 0, 17'h0,    0, 17'h204, 1, 1, 17'h200, 32'h1111_0006);// 34
    // redirect to 0x40 on the completing cycle
    add(0, ST_R, 32'h0,        1, 0, 17'h0,    1, 17'h204, 0, 0, 17'h0,   32'h0);
    add(0, ST_W, 32'h0,        1, 0, 17'h0,    1, 17'h204, 0, 0, 17'h0,   32'h0);
    add(0, ST_W, 32'h0,        1, 0, 17'h0,    1, 17'h204, 0, 0, 17'h0,   32'h0);
    add(0, ST_F, WBAD,         1, 1, 17'h40,   0, 17'h040, 0, 0, 17'h0,   32'h0);        // 38
    add(0, ST_R, 32'h0,        1, 0, 17'h0,    1, 17'h040, 0, 0, 17'h0,   32'h0);
    add(0, ST_W, 32'h0,        1, 0, 17'h0,    1, 17'h040, 0, 0, 17'h0,   32'h0);
    add(0, ST_W, 32'h0,        1, 0, 17'h0,    1, 17'h040, 0, 0, 17'h0,   32'h0);
    add(0, ST_F, 32'h1111_0007,1, 0, 17'h0,    0, 17'h044, 1, 1, 17'h040, 32'h1111_0007);// 42
    // redirect and pop together: flush wins
    add(0, ST_R, 32'h0,        1, 1, 17'h300,  1, 17'h300, 0, 0, 17'h0,   32'h0);        // 43
    add(0, ST_W, 32'h0,        1, 0, 17'h0,    1, 17'h300, 0, 0, 17'h0,   32'h0);
    add(0, ST_W, 32'h0,        1, 0, 17'h0,    1, 17'h300, 0, 0, 17'h0,   32'h0);
    add(0, ST_F, 32'h1111_0008,1, 0, 17'h0,    0, 17'h304, 1, 1, 17'h300, 32'h1111_0008);// 46
    // reset in the middle of a fetch; late result must be ignored
    add(0, ST_R, 32'h0,        1, 0, 17'h0,    1, 17'h304, 0, 0, 17'h0,   32'h0);
    add(0, ST_W, 32'h0,        1, 0, 17'h0,    1, 17'h304, 0, 0, 17'h0,   32'h0);
    add(1, ST_W, 32'h0,        1, 0, 17'h0,    0, 17'h100, 0, 1, 17'h0,   32'h0);        // 49
    add(0, ST_F, WBAD,         1, 0, 17'h0,    1, 17'h100, 0, 0, 17'h0,   32'h0);
    add(0, ST_F, WBAD,         1, 0, 17'h0,    1, 17'h100, 0, 0, 17'h0,   32'h0);        // 51 ignored
    add(0, ST_W, 32'h0,        1, 0, 17'h0,    1, 17'h100, 0, 0, 17'h0,   32'h0);
    add(0, ST_F, 32'h1111_0009,0, 0, 17'h0,    0, 17'h104, 1, 1, 17'h100, 32'h1111_0009);// 53

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      rst = v.rst; inst_fetch_status = v.st; instruction = v.ins;
      dec_ready = v.rdy; redirect = v.rd; redirect_pc = v.rpc;
      @(posedge clk); #1;
      n_tests++;
      ok = (inst_fetch_enabled === v.en) && (inst_addr === v.addr) &&
           (dec_valid === v.val) &&
           (!v.cd || (dec_pc === v.pc && dec_instruction === v.di));
      if (!ok) begin
        n_fail++;
        $display("FAIL vec%0d: en=%b addr=%h valid=%b pc=%h inst=%h, expected en=%b addr=%h valid=%b pc=%h inst=%h",
                 i, inst_fetch_enabled, inst_addr, dec_valid, dec_pc, dec_instruction,
                 v.en, v.addr, v.val, v.pc, v.di);
      end
    end

    // JAL at 0x10 with immediate +0x100
`ifdef IF_JAL_PREDICT_EN
    exp_jal = 17'h110;
`else
    exp_jal = 17'h014;
`endif
    rst = 0; dec_ready = 1; redirect = 1; redirect_pc = 17'h10; inst_fetch_status = ST_R;
    @(posedge clk); #1;
    redirect = 0;
    chk("jal_redirect_addr", 64'(inst_addr), 64'h10);
    chk("jal_redirect_flush", 64'(dec_valid), 64'h0);
    cache_fetch(32'h1000_006F);
    chk("jal_dec_valid", 64'(dec_valid), 64'h1);
    chk("jal_dec_pc", 64'(dec_pc), 64'h10);
    chk("jal_dec_inst", 64'(dec_instruction), 64'h1000_006F);
    chk("jal_next_pc", 64'(inst_addr), 64'(exp_jal));
    @(posedge clk); #1;
    chk("jal_next_fetch_en", 64'(inst_fetch_enabled), 64'h1);
    chk("jal_next_fetch_addr", 64'(inst_addr), 64'(exp_jal));

    // two back-to-back redirects while killing, then PC wrap at the top
    redirect = 1; redirect_pc = 17'h1FFF0;
    @(posedge clk); #1;
    chk("redirect1_addr", 64'(inst_addr), 64'h1FFF0);
    redirect_pc = 17'h1FFFC;
    @(posedge clk); #1;
    redirect = 0;
    chk("redirect2_addr", 64'(inst_addr), 64'h1FFFC);
    cache_fetch(WBAD);
    chk("killed_no_push", 64'(dec_valid), 64'h0);
    chk("killed_pc_kept", 64'(inst_addr), 64'h1FFFC);
    chk("killed_en_drop", 64'(inst_fetch_enabled), 64'h0);
    cache_fetch(32'h1111_000A);
    chk("wrap_dec_pc", 64'(dec_pc), 64'h1FFFC);
    chk("wrap_dec_inst", 64'(dec_instruction), 64'h1111_000A);
    chk("wrap_next_pc", 64'(inst_addr), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
